// File: rtl/traffic_pkg.sv
// Shared types for the highway/country traffic-light slice:
// light codes, detector filter states and a counter sizing helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        ABSENT   = 2'b00,
        QUAL_ON  = 2'b01,
        PRESENT  = 2'b10,
        QUAL_OFF = 2'b11
    } deb_state_t;

    // Bits needed for a stability counter covering both windows.
    function automatic int deb_cnt_w(input int on_n, input int off_n);
        int m;
        int w;
        m = (on_n > off_n) ? on_n : off_n;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sensor_debounce_if.sv
// Detector conditioning bundle: raw line and count clear in,
// qualified level, arrival pulse and vehicle count out.
interface sensor_debounce_if #(
    parameter int CNT_W = 8
);

    logic             car_raw;
    logic             clr_count;
    logic             sensor;
    logic             arrival;
    logic [CNT_W-1:0] car_count;

    modport master (
        output car_raw,
        output clr_count,
        input  sensor,
        input  arrival,
        input  car_count
    );

    modport slave (
        input  car_raw,
        input  clr_count,
        output sensor,
        output arrival,
        output car_count
    );

endinterface

// File: rtl/sensor_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Nothing may sit between the flops.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Plain two-stage capture, cleared to 0 on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sensor_debounce.sv
// Country-road detector filter: sync, presence/absence windows,
// one arrival pulse per qualified vehicle, saturating count.
module sensor_debounce #(
    parameter int DEB_ON  = 4,
    parameter int DEB_OFF = 8,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    sensor_debounce_if.slave bus
);

    import traffic_pkg::*;

    localparam int CW = deb_cnt_w(DEB_ON, DEB_OFF);
    localparam logic [CW-1:0] ON_LAST  = CW'(DEB_ON - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(DEB_OFF - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    deb_state_t       state;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             sensor_q;
    logic             arrival_q;
    logic             qualify;
    logic [CNT_W-1:0] count_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.car_raw),
        .q     (s)
    );

    // Edge that completes a presence window and counts a vehicle.
    always_comb begin
        qualify = (state == QUAL_ON) && s && (cnt == ON_LAST);
    end

    // Filter FSM with registered level and arrival outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ABSENT;
            cnt       <= '0;
            sensor_q  <= 1'b0;
            arrival_q <= 1'b0;
        end else begin
            arrival_q <= 1'b0;
            case (state)
                ABSENT: begin
                    if (s) begin
                        state <= QUAL_ON;
                        cnt   <= CW'(1);
                    end
                end
                QUAL_ON: begin
                    if (!s) begin
                        state <= ABSENT;
                        cnt   <= '0;
                    end else if (cnt == ON_LAST) begin
                        state     <= PRESENT;
                        cnt       <= '0;
                        sensor_q  <= 1'b1;
                        arrival_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (!s) begin
                        state <= QUAL_OFF;
                        cnt   <= CW'(1);
                    end
                end
                QUAL_OFF: begin
                    if (s) begin
                        state <= PRESENT;
                        cnt   <= '0;
                    end else if (cnt == OFF_LAST) begin
                        state    <= ABSENT;
                        cnt      <= '0;
                        sensor_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ABSENT;
                    cnt      <= '0;
                    sensor_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating arrival counter; a clear still counts a same-cycle arrival.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (bus.clr_count) begin
            count_q <= qualify ? ONE : '0;
        end else if (qualify && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.sensor    = sensor_q;
    assign bus.arrival   = arrival_q;
    assign bus.car_count = count_q;

endmodule
